// File: rtl/tage_trace_feeder.sv
// Trace record feeder for the TAGE datapath: prefetches packed branch
// records over req/ack, hands one out per advance, and tracks history/stats.
module tage_trace_feeder #(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 16,
  parameter int GHR_W  = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              instruction_inc_en,
  input  logic              update_enable,
  input  logic              pred_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [PC_W+1:0]   mem_data,
  output logic [PC_W-1:0]   pc_out,
  output logic              taken_out,
  output logic              record_valid,
  output logic [GHR_W-1:0]  ghr,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt,
  output logic [CNT_W-1:0]  underflow_cnt,
  output logic              trace_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t           state;
  logic [PC_W:0]    buf_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;
  logic             push;
  logic             pop;
  logic             last_in;

  assign push    = (state == REQ) && mem_ack;
  assign pop     = instruction_inc_en && (occ != '0);
  assign occ_nxt = occ + OCC_W'(push) - OCC_W'(pop);
  assign last_in = mem_data[PC_W+1];

  assign mem_req    = (state == REQ);
  assign trace_done = (state == DONE) && (occ == '0);

  // Only one request in flight; drop to IDLE when the push fills the buffer.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (occ < FULL) state <= REQ;
        end
        REQ: begin
          if (mem_ack) begin
            mem_addr <= mem_addr + 1'b1;
            if (last_in) state <= DONE;
            else if (occ_nxt >= FULL) state <= IDLE;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) buf_q[wr_ptr] <= mem_data[PC_W:0];
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_nxt;
    end
  end

  // No bypass: a pop only sees records already resident.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pc_out        <= '0;
      taken_out     <= 1'b0;
      record_valid  <= 1'b0;
      underflow_cnt <= '0;
    end else if (instruction_inc_en) begin
      if (pop) begin
        {taken_out, pc_out} <= buf_q[rd_ptr];
        record_valid        <= 1'b1;
      end else begin
        record_valid <= 1'b0;
        if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ghr            <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (update_enable && record_valid) begin
      ghr <= {ghr[GHR_W-2:0], taken_out};
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      if ((pred_in != taken_out) && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tage_trace_feeder.sv
// Bench for tage_trace_feeder: trace-memory responder, queue-based
// reference model and a scoreboard monitor for delivered records.
module tb_tage_trace_feeder;

  localparam int PC_W   = 32;
  localparam int ADDR_W = 16;
  localparam int GHR_W  = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 32;

  logic              CLK = 1'b0;
  logic              reset = 1'b0;
  logic              instruction_inc_en = 1'b0;
  logic              update_enable = 1'b0;
  logic              pred_in = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [PC_W+1:0]   mem_data = '0;
  logic [PC_W-1:0]   pc_out;
  logic              taken_out;
  logic              record_valid;
  logic [GHR_W-1:0]  ghr;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispredict_cnt;
  logic [CNT_W-1:0]  underflow_cnt;
  logic              trace_done;

  always #5 CLK = ~CLK;

  tage_trace_feeder #(
    .PC_W(PC_W), .ADDR_W(ADDR_W), .GHR_W(GHR_W),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .instruction_inc_en(instruction_inc_en),
    .update_enable(update_enable),
    .pred_in(pred_in),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .pc_out(pc_out),
    .taken_out(taken_out),
    .record_valid(record_valid),
    .ghr(ghr),
    .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt),
    .underflow_cnt(underflow_cnt),
    .trace_done(trace_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Trace memory and responder
  logic [PC_W+1:0] tmem [64];
  int lat_lo = 0, lat_hi = 0, cur_lat = 0, wcnt = 0, budget = -1;
  bit spur = 1'b0;

  function automatic logic [PC_W+1:0] mk(bit l, bit t, logic [PC_W-1:0] pc);
    return {l, t, pc};
  endfunction

  function automatic void fill_random(int n_last);
    for (int i = 0; i < 64; i++)
      tmem[i] = mk(i == n_last, 1'($urandom), $urandom);
  endfunction

  function automatic void set_resp(int lo, int hi, int b, bit s);
    lat_lo = lo; lat_hi = hi; cur_lat = lo; budget = b; spur = s; wcnt = 0;
  endfunction

  always @(negedge CLK) begin
    if (reset && mem_req && budget != 0) begin
      if (wcnt >= cur_lat) begin
        mem_ack  = 1'b1;
        mem_data = tmem[mem_addr[5:0]];
        wcnt     = 0;
        cur_lat  = $urandom_range(lat_hi, lat_lo);
        if (budget > 0) budget--;
      end else begin
        mem_ack  = 1'b0;
        mem_data = (PC_W+2)'({$urandom, $urandom});
        wcnt++;
      end
    end else begin
      wcnt     = 0;
      mem_ack  = spur && ($urandom_range(3, 0) == 0);
      mem_data = (PC_W+2)'({$urandom, $urandom});
    end
  end

  // Reference model: FIFO of captured records plus architectural state
  typedef struct packed {
    logic            v;
    logic            t;
    logic [PC_W-1:0] pc;
  } exp_t;

  logic [PC_W:0]     mq [$];
  exp_t              sb [$];
  logic              m_valid = 1'b0;
  logic              m_taken = 1'b0;
  logic [PC_W-1:0]   m_pc = '0;
  logic [GHR_W-1:0]  m_ghr = '0;
  logic [CNT_W-1:0]  m_br = '0, m_mis = '0, m_uf = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  bit                m_last = 1'b0;
  bit                do_push;
  logic [PC_W+1:0]   d_cap;
  exp_t              e_new;

  function automatic void model_clear();
    mq.delete(); sb.delete();
    m_valid = 1'b0; m_taken = 1'b0; m_pc = '0; m_ghr = '0;
    m_br = '0; m_mis = '0; m_uf = '0; m_addr = '0; m_last = 1'b0;
  endfunction

  always @(posedge CLK) begin
    if (reset) begin
      do_push = mem_req && mem_ack;
      d_cap   = mem_data;
      if (update_enable && m_valid) begin
        m_ghr = {m_ghr[GHR_W-2:0], m_taken};
        m_br++;
        if (pred_in != m_taken) m_mis++;
      end
      if (instruction_inc_en) begin
        if (mq.size() > 0) begin
          {m_taken, m_pc} = mq.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_uf++;
        end
        e_new.v = m_valid; e_new.t = m_taken; e_new.pc = m_pc;
        sb.push_back(e_new);
      end
      if (do_push) begin
        mq.push_back(d_cap[PC_W:0]);
        m_addr++;
        if (d_cap[PC_W+1]) m_last = 1'b1;
      end
    end
  end

  // Monitor
  exp_t e_chk;
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      e_chk = sb.pop_front();
      check("record_valid", record_valid, e_chk.v);
      check("pc_out", pc_out, e_chk.pc);
      check("taken_out", taken_out, e_chk.t);
    end
    check("ghr", ghr, m_ghr);
    check("branch_cnt", branch_cnt, m_br);
    check("mispredict_cnt", mispredict_cnt, m_mis);
    check("underflow_cnt", underflow_cnt, m_uf);
    check("mem_addr", mem_addr, m_addr);
    check("trace_done", trace_done, m_last && mq.size() == 0);
    if (m_last || mq.size() == DEPTH) check("mem_req_quiet", mem_req, 0);
  end

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    instruction_inc_en = 1'b0;
    update_enable = 1'b0;
    model_clear();
    tick(2);
    reset = 1'b1;
  endtask

  task automatic step(bit inc, bit upd, bit pred);
    instruction_inc_en = inc;
    update_enable = upd;
    pred_in = pred;
    tick(1);
    instruction_inc_en = 1'b0;
    update_enable = 1'b0;
  endtask

  task automatic cadence(bit pred);
    step(1'b1, 1'b0, 1'b0);
    tick(5);
    step(1'b0, 1'b1, pred);
  endtask

  initial begin
    // reset state
    tick(1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_record_valid", record_valid, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_trace_done", trace_done, 0);

    // zero-latency ack, 4-record trace
    fill_random(-1);
    tmem[0] = mk(0, 1, 32'h100);
    tmem[1] = mk(0, 0, 32'h104);
    tmem[2] = mk(0, 1, 32'h108);
    tmem[3] = mk(1, 0, 32'h10C);
    set_resp(0, 0, -1, 0);
    do_reset();
    tick(8);
    repeat (4) cadence(1'($urandom));
    tick(3);
    check("t1_pc_last", pc_out, 32'h10C);
    check("t1_done", trace_done, 1);
    check("t1_addr", mem_addr, 4);

    // ack never returned
    set_resp(0, 0, 0, 0);
    do_reset();
    tick(5);
    check("t2_req", mem_req, 1);
    check("t2_addr", mem_addr, 0);
    step(1'b1, 1'b0, 1'b0);
    tick(1);
    check("t2_valid", record_valid, 0);
    check("t2_underflow", underflow_cnt, 1);
    step(1'b0, 1'b1, 1'b1);
    tick(2);

    // buffer full
    fill_random(-1);
    set_resp(0, 0, -1, 0);
    do_reset();
    tick(10);
    check("t3_req_full", mem_req, 0);
    check("t3_addr_full", mem_addr, 4);
    step(1'b1, 1'b0, 1'b0);
    tick(1);
    check("t3_req_again", mem_req, 1);
    tick(3);

    // GHR and stats
    tmem[0] = mk(0, 1, 32'h200);
    tmem[1] = mk(0, 0, 32'h204);
    tmem[2] = mk(0, 1, 32'h208);
    set_resp(0, 0, -1, 0);
    do_reset();
    tick(8);
    repeat (3) cadence(1'b1);
    tick(1);
    check("t4_ghr", ghr, 64'b101);
    check("t4_branch", branch_cnt, 3);
    check("t4_mispred", mispredict_cnt, 1);

    // async reset while REQ at address 5
    fill_random(-1);
    set_resp(0, 0, 5, 0);
    do_reset();
    tick(8);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    tick(4);
    check("t5_pre_addr", mem_addr, 5);
    check("t5_pre_req", mem_req, 1);
    #2 reset = 1'b0;
    model_clear();
    #1;
    check("t5_req", mem_req, 0);
    check("t5_addr", mem_addr, 0);
    check("t5_pc", pc_out, 0);
    check("t5_taken", taken_out, 0);
    check("t5_valid", record_valid, 0);
    check("t5_ghr", ghr, 0);
    check("t5_br", branch_cnt, 0);
    check("t5_mis", mispredict_cnt, 0);
    check("t5_uf", underflow_cnt, 0);
    check("t5_done", trace_done, 0);
    tick(2);
    set_resp(0, 0, -1, 0);
    reset = 1'b1;
    check("t5_addr_release", mem_addr, 0);
    tick(6);

    // controller cadence, ack latency 3, 20 records
    fill_random(19);
    set_resp(3, 3, -1, 0);
    do_reset();
    tick(12);
    repeat (20) cadence(1'($urandom));
    tick(3);
    check("t6_underflow", underflow_cnt, 0);
    check("t6_branch", branch_cnt, 20);
    check("t6_done", trace_done, 1);

    // random pulses, random latency, spurious acks
    fill_random(39);
    set_resp(0, 4, -1, 1);
    do_reset();
    repeat (500)
      step($urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0, 1'($urandom));
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
